// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory for the KGP-RISC MEM stage, with a one-cycle registered
// response, misalignment detection and a sequenced zero-fill engine.
module data_mem_ctrl #(
    parameter int DEPTH_LOG2     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [DEPTH_LOG2-1:0]   cnt_reg, cnt_next;

    logic                    accept;
    logic                    access_err;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic [1:0]              lane;
    logic [3:0]              store_be;
    logic [31:0]             store_data;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [3:0]              mem_we;
    logic [31:0]             mem_wdata;
    logic                    rd_en;
    logic [31:0]             rd_word;

    logic                    resp_valid_reg;
    logic                    resp_err_reg;
    logic                    load_reg;
    logic [1:0]              size_reg;
    logic [1:0]              lane_reg;
    logic                    signed_reg;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            CLEAR: begin
                busy     = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == {DEPTH_LOG2{1'b1}}) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else begin
                    // Never advertise readiness while reset is held low.
                    req_ready = reset_n;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept   = req_valid && req_ready;
    assign word_idx = req_addr[DEPTH_LOG2+1:2];
    assign lane     = req_addr[1:0];

    // ---------------- request decode ----------------
    always_comb begin
        access_err = 1'b0;
        store_be   = 4'b0000;
        store_data = req_wdata;
        case (req_size)
            2'b00: begin
                store_be   = 4'b0001 << lane;
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                access_err = lane[0];
                store_be   = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                access_err = (lane != 2'b00);
                store_be   = 4'b1111;
            end
            default: access_err = 1'b1;
        endcase
    end

    always_comb begin
        mem_addr  = word_idx;
        mem_we    = 4'b0000;
        mem_wdata = store_data;
        if (busy) begin
            mem_addr  = cnt_reg;
            mem_we    = 4'b1111;
            mem_wdata = '0;
        end else if (accept && req_write && !access_err) begin
            mem_we = store_be;
        end
    end

    assign rd_en = accept && !req_write && !access_err;

    // ---------------- storage: one byte-wide RAM per lane ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_reg;

        always_ff @(posedge clk) begin
            if (mem_we[gi]) begin
                mem[mem_addr] <= mem_wdata[gi*8 +: 8];
            end
            if (rd_en) begin
                rd_reg <= mem[mem_addr];
            end
        end

        assign rd_word[gi*8 +: 8] = rd_reg;
    end

    // ---------------- response ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            load_reg       <= 1'b0;
            size_reg       <= 2'b00;
            lane_reg       <= 2'b00;
            signed_reg     <= 1'b0;
        end else begin
            resp_valid_reg <= accept;
            resp_err_reg   <= accept && access_err;
            load_reg       <= rd_en;
            if (accept) begin
                size_reg   <= req_size;
                lane_reg   <= lane;
                signed_reg <= req_signed;
            end
        end
    end

    // Lane select and extension act on the registered RAM word and registered
    // request attributes, so the response stays a pure function of flops.
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte   = rd_word[{lane_reg, 3'b000} +: 8];
        sel_half   = lane_reg[1] ? rd_word[31:16] : rd_word[15:0];
        resp_rdata = '0;
        if (load_reg) begin
            case (size_reg)
                2'b00:   resp_rdata = {{24{signed_reg & sel_byte[7]}}, sel_byte};
                2'b01:   resp_rdata = {{16{signed_reg & sel_half[15]}}, sel_half};
                default: resp_rdata = rd_word;
            endcase
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (DEPTH_LOG2=4, CLEAR_ON_RESET=1): expected responses
// are queued at issue time and retired by a negedge response monitor.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    data_mem_ctrl #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Response monitor: every resp_valid pulse retires the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            logic [32:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got err=%0b rdata=%08h, none expected", resp_err, resp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({resp_err, resp_rdata} !== e) begin
                    errors++;
                    $display("FAIL resp: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                             resp_err, resp_rdata, e[32], e[31:0]);
                end else begin
                    $display("resp ok: err=%0b rdata=%08h", resp_err, resp_rdata);
                end
            end
        end
    end

    // Drives one request for one cycle (called just after a rising edge).
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_data);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wd;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready: got %0b, expected 1 (addr %08h)", req_ready, addr);
        end
        $display("req: wr=%0b addr=%08h size=%0d sgn=%0b wdata=%08h", wr, addr, size, sgn, wd);
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // Counts busy cycles at negedges until busy drops; bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, busy} !== 4'b0001 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_vals: got ready=%0b valid=%0b err=%0b busy=%0b rdata=%08h, expected 0 0 0 1 0",
                     req_ready, resp_valid, resp_err, busy, resp_rdata);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL clear_len: got %0d busy cycles, expected 16", n);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_clear: got %0b, expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0000_0000);
    endtask

    task automatic test_store_load;
        issue(1'b1, 32'h08, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(1'b0, 32'h09, 2'b00, 1'b1, 32'h0, 1'b0, 32'hFFFFFFBE);
        issue(1'b0, 32'h0B, 2'b00, 1'b0, 32'h0, 1'b0, 32'h000000DE);
        issue(1'b0, 32'h0A, 2'b01, 1'b1, 32'h0, 1'b0, 32'hFFFFDEAD);
        issue(1'b0, 32'h08, 2'b10, 1'b1, 32'h0, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 32'h08, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0000BEEF);
    endtask

    task automatic test_subword_store;
        issue(1'b1, 32'h0A, 2'b00, 1'b0, 32'hAAAAAA55, 1'b0, 32'h0);
        issue(1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 1'b0, 32'hDE55BEEF);
        issue(1'b1, 32'h08, 2'b01, 1'b0, 32'hFFFF1234, 1'b0, 32'h0);
        issue(1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 1'b0, 32'hDE551234);
    endtask

    task automatic test_misaligned;
        issue(1'b1, 32'h00, 2'b10, 1'b0, 32'h11223344, 1'b0, 32'h0);
        issue(1'b1, 32'h04, 2'b10, 1'b0, 32'h55667788, 1'b0, 32'h0);
        issue(1'b1, 32'h03, 2'b01, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0);
        issue(1'b1, 32'h06, 2'b10, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0);
        issue(1'b1, 32'h00, 2'b11, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0);
        issue(1'b0, 32'h01, 2'b01, 1'b1, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b0, 32'h11223344);
        issue(1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 1'b0, 32'h55667788);
    endtask

    task automatic test_back_to_back;
        idle_cycles(2);
        issue(1'b1, 32'h40, 2'b10, 1'b0, 32'hA5A5_0F0F, 1'b0, 32'h0);
        issue(1'b1, 32'h44, 2'b10, 1'b0, 32'h0123_4567, 1'b0, 32'h0);
        issue(1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b0, 32'hA5A5_0F0F);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third_valid: got %0b, expected 1", resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_drop: got %0b, expected 0", resp_valid);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h06, 2'b01, 1'b0, 32'h0, 1'b0, 32'h00000123);
    endtask

    task automatic test_clear;
        int n;
        idle_cycles(2);
        clear      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h0C;
        req_size   = 2'b10;
        req_wdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: got req_ready=%0b, expected 0", req_ready);
        end
        @(posedge clk);
        #1;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        count_busy(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL cmd_clear_len: got %0d busy cycles, expected 16", n);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);
        issue(1'b1, 32'h14, 2'b10, 1'b0, 32'h7777_7777, 1'b0, 32'h0);
        // Start another clear, then reset it partway through.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reset_mid_clear_len: got %0d busy cycles, expected 16", n);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);
        idle_cycles(3);
    endtask

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_wdata  = '0;
        test_reset();
        test_store_load();
        test_subword_store();
        test_misaligned();
        test_back_to_back();
        test_clear();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_resp: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
